// File: rtl/rf_scoreboard_reg_file_pkg.sv
// Shared ISA types for the integer register file and its busy scoreboard.
package rf_scoreboard_reg_file_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned RF_DEPTH       = 32;
    localparam int unsigned RF_ADDR_WIDTH  = 5;
    localparam int unsigned RF_COUNT_WIDTH = 6;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DEPTH-1:0]      rf_busy_t;

    localparam rf_addr_t X0 = '0;

    // X0 is hardwired and never counted as busy.
    function automatic logic [RF_COUNT_WIDTH-1:0] busy_popcount(input rf_busy_t b);
        logic [RF_COUNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 1; i < RF_DEPTH; i++) begin
            cnt = cnt + RF_COUNT_WIDTH'(b[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_scoreboard_reg_file_if.sv
// Decode / write-back / execute bundle of the register file.
interface rf_scoreboard_reg_file_if;
    import rf_scoreboard_reg_file_pkg::*;

    rf_addr_t                  rd_addr_1;
    word_t                     rd_data_1;
    logic                      rd_busy_1;
    rf_addr_t                  rd_addr_2;
    word_t                     rd_data_2;
    logic                      rd_busy_2;
    logic                      wr_en;
    rf_addr_t                  wr_addr;
    word_t                     wr_data;
    logic                      rsv_en;
    rf_addr_t                  rsv_addr;
    logic                      rsv_stall;
    logic                      flush;
    logic [RF_COUNT_WIDTH-1:0] busy_count;

    modport master (
        output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data_1, rd_busy_1, rd_data_2, rd_busy_2, rsv_stall, busy_count
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data_1, rd_busy_1, rd_data_2, rd_busy_2, rsv_stall, busy_count
    );

endinterface

// File: rtl/rf_busy_scoreboard.sv
// Per-register busy bits: reservation at decode, release at write-back, flush.
module rf_busy_scoreboard
    import rf_scoreboard_reg_file_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rsv_en_i,
    input  rf_addr_t                  rsv_addr_i,
    input  logic                      wr_en_i,
    input  rf_addr_t                  wr_addr_i,
    input  logic                      flush_i,
    input  rf_addr_t                  rd_addr_1_i,
    input  rf_addr_t                  rd_addr_2_i,
    output logic                      rsv_stall_o,
    output logic                      rd_busy_1_o,
    output logic                      rd_busy_2_o,
    output logic [RF_COUNT_WIDTH-1:0] busy_count_o
);

    rf_busy_t                  busy_q, busy_d;
    logic [RF_COUNT_WIDTH-1:0] count_q, count_d;
    logic                      wr_commit;

    assign wr_commit = wr_en_i && (wr_addr_i != X0);

    // A commit landing this cycle hides the busy bit it is about to clear.
    assign rsv_stall_o = rsv_en_i && busy_q[rsv_addr_i]
                         && !(BYPASS_EN && wr_en_i && (wr_addr_i == rsv_addr_i));
    assign rd_busy_1_o = busy_q[rd_addr_1_i]
                         && !(BYPASS_EN && wr_en_i && (wr_addr_i == rd_addr_1_i));
    assign rd_busy_2_o = busy_q[rd_addr_2_i]
                         && !(BYPASS_EN && wr_en_i && (wr_addr_i == rd_addr_2_i));

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_commit) begin
                busy_d[wr_addr_i] = 1'b0;
            end
            // Set after clear: a younger reservation outranks an older commit.
            if (rsv_en_i && !rsv_stall_o && (rsv_addr_i != X0)) begin
                busy_d[rsv_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        count_d   = busy_popcount(busy_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count_o = count_q;

    c_write_not_busy : cover property (@(posedge clk) disable iff (!rst_n)
        wr_commit && !busy_q[wr_addr_i]);

endmodule

// File: rtl/rf_scoreboard_reg_file.sv
// RV32I register file: two combinational read ports, one write port, busy scoreboard.
module rf_scoreboard_reg_file
    import rf_scoreboard_reg_file_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    rf_scoreboard_reg_file_if.slave bus_io
);

    word_t regs_q [RF_DEPTH];
    word_t rdata_1, rdata_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus_io.wr_en && (bus_io.wr_addr != X0)) begin
            regs_q[bus_io.wr_addr] <= bus_io.wr_data;
        end
    end

    always_comb begin
        rdata_1 = regs_q[bus_io.rd_addr_1];
        if (BYPASS_EN && bus_io.wr_en && (bus_io.wr_addr == bus_io.rd_addr_1)) begin
            rdata_1 = bus_io.wr_data;
        end
        if (bus_io.rd_addr_1 == X0) begin
            rdata_1 = '0;
        end
    end

    always_comb begin
        rdata_2 = regs_q[bus_io.rd_addr_2];
        if (BYPASS_EN && bus_io.wr_en && (bus_io.wr_addr == bus_io.rd_addr_2)) begin
            rdata_2 = bus_io.wr_data;
        end
        if (bus_io.rd_addr_2 == X0) begin
            rdata_2 = '0;
        end
    end

    assign bus_io.rd_data_1 = rdata_1;
    assign bus_io.rd_data_2 = rdata_2;

    rf_busy_scoreboard #(
        .BYPASS_EN(BYPASS_EN)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsv_en_i    (bus_io.rsv_en),
        .rsv_addr_i  (bus_io.rsv_addr),
        .wr_en_i     (bus_io.wr_en),
        .wr_addr_i   (bus_io.wr_addr),
        .flush_i     (bus_io.flush),
        .rd_addr_1_i (bus_io.rd_addr_1),
        .rd_addr_2_i (bus_io.rd_addr_2),
        .rsv_stall_o (bus_io.rsv_stall),
        .rd_busy_1_o (bus_io.rd_busy_1),
        .rd_busy_2_o (bus_io.rd_busy_2),
        .busy_count_o(bus_io.busy_count)
    );

endmodule

// File: tb/tb_rf_scoreboard_reg_file.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus.
module tb_rf_scoreboard_reg_file;
    import rf_scoreboard_reg_file_pkg::*;

    logic     clk;
    logic     rst_n;
    rf_addr_t rd_addr_1, rd_addr_2, wr_addr, rsv_addr;
    logic     wr_en, rsv_en, flush;
    word_t    wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state; index 0 = bypass variant, 1 = no-bypass variant.
    word_t m_reg  [32];
    bit    m_busy [2][32];

    rf_scoreboard_reg_file_if u_if_b ();
    rf_scoreboard_reg_file_if u_if_n ();

    assign u_if_b.rd_addr_1 = rd_addr_1;
    assign u_if_b.rd_addr_2 = rd_addr_2;
    assign u_if_b.wr_en     = wr_en;
    assign u_if_b.wr_addr   = wr_addr;
    assign u_if_b.wr_data   = wr_data;
    assign u_if_b.rsv_en    = rsv_en;
    assign u_if_b.rsv_addr  = rsv_addr;
    assign u_if_b.flush     = flush;
    assign u_if_n.rd_addr_1 = rd_addr_1;
    assign u_if_n.rd_addr_2 = rd_addr_2;
    assign u_if_n.wr_en     = wr_en;
    assign u_if_n.wr_addr   = wr_addr;
    assign u_if_n.wr_data   = wr_data;
    assign u_if_n.rsv_en    = rsv_en;
    assign u_if_n.rsv_addr  = rsv_addr;
    assign u_if_n.flush     = flush;

    rf_scoreboard_reg_file #(.BYPASS_EN(1'b1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(u_if_b)
    );

    rf_scoreboard_reg_file #(.BYPASS_EN(1'b0)) u_dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(u_if_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic word_t exp_rd(input int v, input rf_addr_t a);
        if (a == 0) return '0;
        if (v == 0 && wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_rbusy(input int v, input rf_addr_t a);
        if (a == 0) return 1'b0;
        return m_busy[v][a] && !(v == 0 && wr_en && wr_addr == a);
    endfunction

    function automatic logic exp_stall(input int v);
        if (!rsv_en || rsv_addr == 0) return 1'b0;
        return m_busy[v][rsv_addr] && !(v == 0 && wr_en && wr_addr == rsv_addr);
    endfunction

    function automatic int exp_count(input int v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[v][i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]     = '0;
            m_busy[0][i] = 1'b0;
            m_busy[1][i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int v = 0; v < 2; v++) begin
            logic stall;
            stall = exp_stall(v);
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[v][i] = 1'b0;
            end else begin
                if (wr_en && wr_addr != 0) m_busy[v][wr_addr] = 1'b0;
                if (rsv_en && !stall && rsv_addr != 0) m_busy[v][rsv_addr] = 1'b1;
            end
        end
        if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle comparison of every output of both instances against the model.
    task automatic sample();
        @(negedge clk);
        check("b.rd_data_1", u_if_b.rd_data_1, exp_rd(0, rd_addr_1));
        check("b.rd_data_2", u_if_b.rd_data_2, exp_rd(0, rd_addr_2));
        check("b.rd_busy_1", 32'(u_if_b.rd_busy_1), 32'(exp_rbusy(0, rd_addr_1)));
        check("b.rd_busy_2", 32'(u_if_b.rd_busy_2), 32'(exp_rbusy(0, rd_addr_2)));
        check("b.rsv_stall", 32'(u_if_b.rsv_stall), 32'(exp_stall(0)));
        check("b.busy_count", 32'(u_if_b.busy_count), 32'(exp_count(0)));
        check("n.rd_data_1", u_if_n.rd_data_1, exp_rd(1, rd_addr_1));
        check("n.rd_data_2", u_if_n.rd_data_2, exp_rd(1, rd_addr_2));
        check("n.rd_busy_1", 32'(u_if_n.rd_busy_1), 32'(exp_rbusy(1, rd_addr_1)));
        check("n.rd_busy_2", 32'(u_if_n.rd_busy_2), 32'(exp_rbusy(1, rd_addr_2)));
        check("n.rsv_stall", 32'(u_if_n.rsv_stall), 32'(exp_stall(1)));
        check("n.busy_count", 32'(u_if_n.busy_count), 32'(exp_count(1)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_addr_1 = 5'd5;
        rd_addr_2 = 5'd6;
        wr_addr   = '0;
        rsv_addr  = '0;
        wr_data   = '0;
        idle();
        model_reset();
        sample();
        check("reset.count", 32'(u_if_b.busy_count), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Reset mid-operation, observed without any clock edge
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        sample(); tick();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6;
        sample(); tick();
        idle(); rd_addr_1 = 5'd5; rd_addr_2 = 5'd6;
        sample();
        check("pre_rst.x5", u_if_b.rd_data_1, 32'hDEAD_BEEF);
        check("pre_rst.x6_busy", 32'(u_if_b.rd_busy_2), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.x5_b", u_if_b.rd_data_1, 32'd0);
        check("rst.x5_n", u_if_n.rd_data_1, 32'd0);
        check("rst.x6_busy", 32'(u_if_b.rd_busy_2), 32'd0);
        check("rst.count_b", 32'(u_if_b.busy_count), 32'd0);
        check("rst.count_n", 32'(u_if_n.busy_count), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // X0 protection
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr_1 = 5'd0;
        sample();
        check("x0.rd_data", u_if_b.rd_data_1, 32'd0);
        check("x0.rd_busy", 32'(u_if_b.rd_busy_1), 32'd0);
        check("x0.stall", 32'(u_if_b.rsv_stall), 32'd0);
        tick();
        idle();
        sample();
        check("x0.count", 32'(u_if_b.busy_count), 32'd0);
        tick();

        // Reserve then commit x7
        rsv_en = 1'b1; rsv_addr = 5'd7;
        sample(); tick();
        idle(); rd_addr_2 = 5'd7;
        sample();
        check("rc.busy", 32'(u_if_b.rd_busy_2), 32'd1);
        check("rc.count1", 32'(u_if_b.busy_count), 32'd1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
        sample();
        check("rc.bypass_data", u_if_b.rd_data_2, 32'h1234_5678);
        check("rc.bypass_busy", 32'(u_if_b.rd_busy_2), 32'd0);
        tick();
        idle();
        sample();
        check("rc.count0", 32'(u_if_b.busy_count), 32'd0);
        tick();

        // WAW stall on x9, with and without a same-cycle commit
        rsv_en = 1'b1; rsv_addr = 5'd9;
        sample(); tick();
        sample();
        check("waw.stall", 32'(u_if_b.rsv_stall), 32'd1);
        tick();
        idle();
        sample();
        check("waw.count", 32'(u_if_b.busy_count), 32'd1);
        tick();
        rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        rd_addr_1 = 5'd9;
        sample();
        check("waw.commit_stall", 32'(u_if_b.rsv_stall), 32'd0);
        tick();
        idle();
        sample();
        check("waw.still_busy", 32'(u_if_b.rd_busy_1), 32'd1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd9;
        sample(); tick();

        // Flush with a same-cycle reservation and write
        for (int a = 1; a <= 4; a++) begin
            idle(); rsv_en = 1'b1; rsv_addr = rf_addr_t'(a);
            sample(); tick();
        end
        idle();
        sample();
        check("fl.count4", 32'(u_if_b.busy_count), 32'd4);
        tick();
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
        sample(); tick();
        idle(); rd_addr_1 = 5'd10; rd_addr_2 = 5'd2;
        sample();
        check("fl.count0", 32'(u_if_b.busy_count), 32'd0);
        check("fl.x10_busy", 32'(u_if_b.rd_busy_1), 32'd0);
        check("fl.x2_data", u_if_b.rd_data_2, 32'h0000_0055);
        tick();

        // Bypass off: stored value until the edge
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_AAAA;
        sample(); tick();
        wr_data = 32'h5555_5555; rd_addr_1 = 5'd3;
        sample();
        check("nb.old", u_if_n.rd_data_1, 32'hAAAA_AAAA);
        check("nb.byp", u_if_b.rd_data_1, 32'h5555_5555);
        tick();
        idle();
        sample();
        check("nb.new", u_if_n.rd_data_1, 32'h5555_5555);
        tick();

        // Random traffic on a narrow address range to force collisions
        repeat (400) begin
            wr_en     = 1'($urandom_range(0, 1));
            rsv_en    = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            wr_addr   = rf_addr_t'($urandom_range(0, 7));
            rsv_addr  = rf_addr_t'($urandom_range(0, 7));
            rd_addr_1 = rf_addr_t'($urandom_range(0, 7));
            rd_addr_2 = rf_addr_t'($urandom_range(0, 31));
            wr_data   = $urandom;
            sample();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
